// File: rtl/sdc_card_cmd_responder_pkg.sv
// Shared definitions for the SD card-side CMD responder: FSM encoding,
// frame lengths and fixed CMD-line field values.
package sdc_card_cmd_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX       = 3'd1,
    ST_CHECK    = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_TX       = 3'd4
  } state_e;

  localparam int         CMD_FRAME_LEN = 48;
  localparam int         RSP_LONG_LEN  = 136;
  localparam logic [6:0] CRC7_POLY     = 7'h09;
  localparam logic [5:0] R2_INDEX      = 6'h3F;
  localparam logic [6:0] NO_CRC_FIELD  = 7'h7F;

endpackage

// File: rtl/sdc_card_cmd_responder_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock, MSB-first data.
module sdc_crc7
  import sdc_card_cmd_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = bit_i ^ crc_q[6];
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 7'd0;
    end else if (en_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= 7'd0;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sdc_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit commands, answers with 48/136-bit
// responses. Define SDC_RSP_FALL_LAUNCH_EN to launch CMD drive on the falling edge.
module sdc_card_cmd_responder
  import sdc_card_cmd_responder_pkg::*;
#(
  parameter int NCR_MIN     = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic         sd_clk_i,
  input  logic         rst_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_out_o,
  output logic         sd_cmd_oe_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_crc_err_o,
  input  logic         rsp_valid_i,
  output logic         rsp_ready_o,
  input  logic         rsp_long_i,
  input  logic         rsp_no_crc_i,
  input  logic [5:0]   rsp_index_i,
  input  logic [127:0] rsp_payload_i,
  output logic         rsp_done_o
);

  localparam int N_W = $clog2(RSP_TIMEOUT + NCR_MIN + 2);

  // Handshake: a response is taken on any rising edge where rsp_valid_i and
  // rsp_ready_o are both high; rsp_ready_o is only high while a command waits.
  state_e         state_q, state_d;
  logic [5:0]     rx_cnt_q, rx_cnt_d;
  logic [45:0]    rx_sr_q, rx_sr_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic           cmd_crc_err_q, cmd_crc_err_d;
  logic [5:0]     cmd_index_q, cmd_index_d;
  logic [31:0]    cmd_arg_q, cmd_arg_d;
  logic           ready_q, ready_d;
  logic           have_q, have_d;
  logic [N_W-1:0] n_q, n_d;
  logic [135:0]   tx_frame_q, tx_frame_d;
  logic           tx_long_q, tx_long_d;
  logic           tx_no_crc_q, tx_no_crc_d;
  logic [7:0]     tx_cnt_q, tx_cnt_d;
  logic           out_q, out_d;
  logic           oe_q, oe_d;
  logic           done_q, done_d;

  logic [46:0]    rx_full;
  logic [6:0]     crc_rx, crc_tx;
  logic           hs, tx_clr, tx_crc_en, tx_crc_bit, nb_bit;
  logic [7:0]     nb, tx_last;
  logic [2:0]     crc_sel;

  sdc_crc7 u_crc_rx (
    .clk_i (sd_clk_i),
    .rst_i (rst_i),
    .clr_i (state_q == ST_IDLE),
    .en_i  (state_q == ST_RX && rx_cnt_q < 6'd39),
    .bit_i (sd_cmd_i),
    .crc_o (crc_rx)
  );

  sdc_crc7 u_crc_tx (
    .clk_i (sd_clk_i),
    .rst_i (rst_i),
    .clr_i (tx_clr),
    .en_i  (tx_crc_en),
    .bit_i (tx_crc_bit),
    .crc_o (crc_tx)
  );

  always_comb begin
    state_d       = state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_sr_d       = rx_sr_q;
    cmd_valid_d   = 1'b0;
    cmd_crc_err_d = 1'b0;
    cmd_index_d   = cmd_index_q;
    cmd_arg_d     = cmd_arg_q;
    ready_d       = ready_q;
    have_d        = have_q;
    n_d           = n_q;
    tx_frame_d    = tx_frame_q;
    tx_long_d     = tx_long_q;
    tx_no_crc_d   = tx_no_crc_q;
    tx_cnt_d      = tx_cnt_q;
    out_d         = out_q;
    oe_d          = oe_q;
    done_d        = 1'b0;
    tx_clr        = 1'b0;
    tx_crc_en     = 1'b0;
    tx_crc_bit    = 1'b0;
    rx_full       = {rx_sr_q, sd_cmd_i};
    hs            = rsp_valid_i & ready_q;
    nb            = tx_cnt_q + 8'd1;
    nb_bit        = tx_frame_q[8'd135 - nb];
    tx_last       = tx_long_q ? 8'(RSP_LONG_LEN - 1) : 8'(CMD_FRAME_LEN - 1);
    crc_sel       = 3'd6 - nb[2:0];

    case (state_q)
      ST_IDLE: begin
        out_d = 1'b1;
        oe_d  = 1'b0;
        if (!sd_cmd_i) begin
          state_d  = ST_RX;
          rx_cnt_d = 6'd0;
        end
      end

      ST_RX: begin
        rx_sr_d  = rx_full[45:0];
        rx_cnt_d = rx_cnt_q + 6'd1;
        if (rx_cnt_q == 6'd46) begin
          state_d = ST_CHECK;
          n_d     = N_W'(1);
          // Transmission bit 0 is another device's response: drop it quietly.
          if (rx_full[46]) begin
            cmd_valid_d   = 1'b1;
            cmd_index_d   = rx_full[45:40];
            cmd_arg_d     = rx_full[39:8];
            cmd_crc_err_d = (rx_full[7:1] != crc_rx) | ~rx_full[0];
            ready_d       = ~cmd_crc_err_d;
          end
        end
      end

      ST_CHECK, ST_WAIT_RSP: begin
        state_d = ST_WAIT_RSP;
        n_d     = n_q + 1'b1;
        if (hs) begin
          have_d      = 1'b1;
          ready_d     = 1'b0;
          tx_long_d   = rsp_long_i;
          tx_no_crc_d = rsp_no_crc_i & ~rsp_long_i;
          tx_frame_d  = rsp_long_i ?
                        {2'b00, R2_INDEX, rsp_payload_i[127:1], 1'b1} :
                        {2'b00, rsp_index_i, rsp_payload_i[31:0], NO_CRC_FIELD, 1'b1, 88'd0};
        end
        if (have_q || hs) begin
          // Launch the start bit once the next cycle satisfies Ncr.
          if (int'(n_q) + 1 >= NCR_MIN) begin
            state_d  = ST_TX;
            have_d   = 1'b0;
            out_d    = 1'b0;
            oe_d     = 1'b1;
            tx_cnt_d = 8'd0;
            tx_clr   = 1'b1;
          end
        end else if (!ready_q) begin
          state_d = ST_IDLE;
        end else if (int'(n_q) + 1 >= RSP_TIMEOUT) begin
          ready_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_TX: begin
        if (tx_cnt_q == tx_last) begin
          out_d   = 1'b1;
          oe_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tx_cnt_d = nb;
          out_d    = nb_bit;
          if (!tx_long_q && !tx_no_crc_q && nb >= 8'd40 && nb <= 8'd46) out_d = crc_tx[crc_sel];
          // Bit 0 is always a 0 start bit, a no-op for CRC, so feeding starts at bit 1.
          if (nb <= 8'd39) begin
            tx_crc_en  = 1'b1;
            tx_crc_bit = nb_bit;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rx_cnt_q      <= 6'd0;
      rx_sr_q       <= 46'd0;
      cmd_valid_q   <= 1'b0;
      cmd_crc_err_q <= 1'b0;
      cmd_index_q   <= 6'd0;
      cmd_arg_q     <= 32'd0;
      ready_q       <= 1'b0;
      have_q        <= 1'b0;
      n_q           <= '0;
      tx_frame_q    <= 136'd0;
      tx_long_q     <= 1'b0;
      tx_no_crc_q   <= 1'b0;
      tx_cnt_q      <= 8'd0;
      out_q         <= 1'b1;
      oe_q          <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_sr_q       <= rx_sr_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_crc_err_q <= cmd_crc_err_d;
      cmd_index_q   <= cmd_index_d;
      cmd_arg_q     <= cmd_arg_d;
      ready_q       <= ready_d;
      have_q        <= have_d;
      n_q           <= n_d;
      tx_frame_q    <= tx_frame_d;
      tx_long_q     <= tx_long_d;
      tx_no_crc_q   <= tx_no_crc_d;
      tx_cnt_q      <= tx_cnt_d;
      out_q         <= out_d;
      oe_q          <= oe_d;
      done_q        <= done_d;
    end
  end

`ifdef SDC_RSP_FALL_LAUNCH_EN
  logic out_f_q, oe_f_q;

  always_ff @(negedge sd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_f_q <= 1'b1;
      oe_f_q  <= 1'b0;
    end else begin
      out_f_q <= out_q;
      oe_f_q  <= oe_q;
    end
  end

  assign sd_cmd_out_o = out_f_q;
  assign sd_cmd_oe_o  = oe_f_q;
`else
  assign sd_cmd_out_o = out_q;
  assign sd_cmd_oe_o  = oe_q;
`endif

  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_index_o   = cmd_index_q;
  assign cmd_arg_o     = cmd_arg_q;
  assign cmd_crc_err_o = cmd_crc_err_q;
  assign rsp_ready_o   = ready_q;
  assign rsp_done_o    = done_q;

endmodule

// File: tb/tb_sdc_card_cmd_responder.sv
// Bench for sdc_card_cmd_responder: host-side command driver, cycle-by-cycle
// comparison of CMD outputs against a frame-level reference model.
module tb_sdc_card_cmd_responder;

  localparam int NCR_MIN     = 2;
  localparam int RSP_TIMEOUT = 64;

  logic         sd_clk_i = 1'b0;
  logic         rst_i;
  logic         sd_cmd_i;
  logic         sd_cmd_out_o;
  logic         sd_cmd_oe_o;
  logic         cmd_valid_o;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_crc_err_o;
  logic         rsp_valid_i;
  logic         rsp_ready_o;
  logic         rsp_long_i;
  logic         rsp_no_crc_i;
  logic [5:0]   rsp_index_i;
  logic [127:0] rsp_payload_i;
  logic         rsp_done_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock and reset
  always #5 sd_clk_i = ~sd_clk_i;

  sdc_card_cmd_responder #(.NCR_MIN(NCR_MIN), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .sd_clk_i      (sd_clk_i),
    .rst_i         (rst_i),
    .sd_cmd_i      (sd_cmd_i),
    .sd_cmd_out_o  (sd_cmd_out_o),
    .sd_cmd_oe_o   (sd_cmd_oe_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_index_o   (cmd_index_o),
    .cmd_arg_o     (cmd_arg_o),
    .cmd_crc_err_o (cmd_crc_err_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_long_i    (rsp_long_i),
    .rsp_no_crc_i  (rsp_no_crc_i),
    .rsp_index_i   (rsp_index_i),
    .rsp_payload_i (rsp_payload_i),
    .rsp_done_o    (rsp_done_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // CRC7 as the remainder of data * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic junk_rsp_inputs();
    rsp_long_i    = 1'($urandom_range(0, 1));
    rsp_no_crc_i  = 1'($urandom_range(0, 1));
    rsp_index_i   = 6'($urandom);
    rsp_payload_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Driver: one bit per cycle, changed half a cycle before the sampling edge.
  task automatic send_cmd(input logic [47:0] frame);
    for (int i = 47; i >= 0; i--) begin
      sd_cmd_i    = frame[i];
      rsp_valid_i = 1'($urandom_range(0, 1));
      junk_rsp_inputs();
      @(negedge sd_clk_i); #1;
    end
    sd_cmd_i = 1'b1;
  endtask

  // One full exchange. Cycle t counts clocks after the command end bit (CHECK is t=1).
  // h: cycle in which rsp_valid_i is offered; abort: cycle in which rst_i is pulsed (0 = none).
  task automatic do_cmd(input logic [47:0] frame, input int h, input logic long_r, input logic no_crc,
                        input logic [5:0] idx, input logic [127:0] pl, input int abort);
    logic [0:0] exp_q[$];
    logic       valid, err, good, hs_ok, tx_on, exp_out;
    logic [6:0] c;
    int         s, len, last, ready_last;
    bit         aborted;

    valid = frame[46];
    err   = (crc7_ref(frame[47:8]) != frame[7:1]) || !frame[0];
    good  = valid && !err;
    hs_ok = good && h >= 1 && h <= RSP_TIMEOUT - 1;
    s     = (h + 1 > NCR_MIN) ? h + 1 : NCR_MIN;
    exp_q = {};
    if (hs_ok) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      if (long_r) begin
        for (int i = 0; i < 6; i++) exp_q.push_back(1'b1);
        for (int i = 127; i >= 1; i--) exp_q.push_back(pl[i]);
      end else begin
        c = no_crc ? 7'h7F : crc7_ref({2'b00, idx, pl[31:0]});
        for (int i = 5; i >= 0; i--) exp_q.push_back(idx[i]);
        for (int i = 31; i >= 0; i--) exp_q.push_back(pl[i]);
        for (int i = 6; i >= 0; i--) exp_q.push_back(c[i]);
      end
      exp_q.push_back(1'b1);
    end
    len        = exp_q.size();
    last       = hs_ok ? s + len + 2 : RSP_TIMEOUT + 2;
    ready_last = hs_ok ? h : RSP_TIMEOUT - 1;
    aborted    = 1'b0;

    send_cmd(frame);
    for (int t = 1; t <= last; t++) begin
      check_eq("cmd_valid", cmd_valid_o, (t == 1) && valid);
      if (t == 1 && valid) begin
        check_eq("cmd_index", cmd_index_o, frame[45:40]);
        check_eq("cmd_arg", cmd_arg_o, frame[39:8]);
        check_eq("cmd_crc_err", cmd_crc_err_o, err);
      end
      check_eq("rsp_ready", rsp_ready_o, good && t <= ready_last);
      tx_on   = hs_ok && t >= s && t < s + len;
      exp_out = tx_on ? exp_q[t - s] : 1'b1;
      check_eq("cmd_oe", sd_cmd_oe_o, tx_on);
      check_eq("cmd_out", sd_cmd_out_o, exp_out);
      check_eq("rsp_done", rsp_done_o, hs_ok && t == s + len);
      if (t == abort) begin
        #2 rst_i = 1'b1;
        #1;
        check_eq("abort_oe", sd_cmd_oe_o, 1'b0);
        check_eq("abort_out", sd_cmd_out_o, 1'b1);
        check_eq("abort_ready", rsp_ready_o, 1'b0);
        check_eq("abort_done", rsp_done_o, 1'b0);
        @(negedge sd_clk_i); #1;
        rst_i   = 1'b0;
        aborted = 1'b1;
      end
      if (aborted) break;
      if (t == h) begin
        rsp_valid_i   = 1'b1;
        rsp_long_i    = long_r;
        rsp_no_crc_i  = no_crc;
        rsp_index_i   = idx;
        rsp_payload_i = pl;
      end else begin
        rsp_valid_i = 1'b0;
        junk_rsp_inputs();
      end
      @(negedge sd_clk_i); #1;
    end
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    logic [47:0] f;
    int          h;
    rst_i       = 1'b1;
    sd_cmd_i    = 1'b1;
    rsp_valid_i = 1'b0;
    junk_rsp_inputs();
    repeat (2) @(negedge sd_clk_i);
    #1;
    check_eq("rst_oe", sd_cmd_oe_o, 1'b0);
    check_eq("rst_out", sd_cmd_out_o, 1'b1);
    check_eq("rst_valid", cmd_valid_o, 1'b0);
    check_eq("rst_index", cmd_index_o, 6'd0);
    check_eq("rst_arg", cmd_arg_o, 32'd0);
    check_eq("rst_crc_err", cmd_crc_err_o, 1'b0);
    check_eq("rst_ready", rsp_ready_o, 1'b0);
    check_eq("rst_done", rsp_done_o, 1'b0);
    rst_i = 1'b0;
    repeat (2) begin @(negedge sd_clk_i); #1; end

    // CMD0, card model silent: ready times out, CMD never driven
    do_cmd(48'h400000000095, 1000, 1'b0, 1'b0, 6'd0, 128'd0, 0);
    // CMD8 answered at once with R7
    do_cmd(48'h48000001AA87, 1, 1'b0, 1'b0, 6'd8, 128'h1AA, 0);
    // CMD0 with corrupted CRC
    do_cmd(48'h400000000097, 1, 1'b0, 1'b0, 6'd0, 128'h5, 0);
    // Transmission bit 0, then a normal CMD0
    do_cmd(48'h000000000001, 1, 1'b0, 1'b0, 6'd0, 128'h5, 0);
    do_cmd(48'h400000000095, 5, 1'b0, 1'b0, 6'd0, 128'hCAFEF00D, 0);
    // R2 accepted at end+10
    do_cmd(make_cmd(6'd2, 32'd0), 10, 1'b1, 1'b0, 6'd0, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
    // R3 with no CRC
    do_cmd(make_cmd(6'd41, $urandom), $urandom_range(1, 20), 1'b0, 1'b1, 6'h3F,
           {$urandom, $urandom, $urandom, $urandom}, 0);
    // Reset in the middle of a response, then a fresh command
    do_cmd(make_cmd(6'd17, $urandom), 3, 1'b0, 1'b0, 6'd17, {96'd0, $urandom}, 14);
    do_cmd(48'h400000000095, 2, 1'b0, 1'b0, 6'd0, 128'h900, 0);

    for (int k = 0; k < 10; k++) begin
      f = make_cmd(6'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) f = f ^ (48'd1 << $urandom_range(0, 46));
      h = $urandom_range(1, 70);
      do_cmd(f, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
